// File: rtl/add_sub_result_pack_unit.sv
// Add/sub result pack stage: merges special-case select codes with the normal path into an
// IEEE-754 single word, one output register plus a skid entry. Optional flags: ADD_SUB_RES_FLAGS_EN.
module add_sub_result_pack_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_add_sub,
    input  logic             i_sign_a,
    input  logic             i_sign_b,
    input  logic [1:0]       i_sel_exp,
    input  logic [1:0]       i_sel_man,
    input  logic             i_sign_n,
    input  logic [7:0]       i_exp_n,
    input  logic [22:0]      i_man_n,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic             o_is_nan,
    output logic             o_is_inf,
    output logic             o_is_zero,
    input  logic             i_flag_clr,
    output logic             o_flag_nan,
    output logic             o_flag_inf,
    output logic             o_flag_zero,
    output logic [CNT_W-1:0] o_cnt_nan,
    output logic [CNT_W-1:0] o_cnt_inf,
    output logic [CNT_W-1:0] o_cnt_zero
);

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
    localparam logic [WORD_W-1:0] QNAN_WORD = 32'h7FC0_0000;

    typedef struct packed {
        logic [WORD_W-1:0] result;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } beat_t;

    beat_t in_beat;
    beat_t out_q;
    beat_t skid_q;
    logic  skid_valid;
    logic  accept;
    logic  out_free;
    logic  eff_b;
    logic  dec_nan;
    logic  dec_inf;
    logic  dec_zero;

    assign accept   = i_valid & o_ready;
    assign out_free = ~o_valid | i_ready;
    assign eff_b    = i_sign_b ^ i_add_sub;

    // Priority decode: NaN, then Inf, then Zero, else normal path.
    always_comb begin
        in_beat  = '0;
        dec_nan  = (i_sel_man == 2'b11);
        dec_inf  = ~dec_nan & ((i_sel_man == 2'b10) | (i_sel_exp[0] & ~i_sel_man[0]));
        dec_zero = ~dec_nan & ~dec_inf & i_sel_exp[1];
        in_beat.is_nan  = dec_nan;
        in_beat.is_inf  = dec_inf;
        in_beat.is_zero = dec_zero;
        if (dec_nan) begin
            in_beat.result = QNAN_WORD;
        end else if (dec_inf) begin
            in_beat.result = {i_sign_n, {EXP_W{1'b1}}, MAN_W'(0)};
        end else if (dec_zero) begin
            in_beat.result = {i_sign_a & eff_b, (WORD_W - 1)'(0)};
        end else begin
            in_beat.result = {i_sign_n, i_exp_n, i_man_n};
        end
    end

    // Output register refills from the skid entry first so ordering is preserved.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
        end else if (out_free) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                o_valid    <= 1'b1;
                skid_valid <= 1'b0;
                o_ready    <= 1'b1;
            end else if (accept) begin
                out_q   <= in_beat;
                o_valid <= 1'b1;
            end else begin
                o_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
            o_ready    <= 1'b0;
        end
    end

    assign o_result  = out_q.result;
    assign o_is_nan  = out_q.is_nan;
    assign o_is_inf  = out_q.is_inf;
    assign o_is_zero = out_q.is_zero;

`ifdef ADD_SUB_RES_FLAGS_EN
    logic [2:0]       event_vec;
    logic [2:0]       flag_q;
    logic [CNT_W-1:0] cnt_q [3];

    assign event_vec = {o_is_nan, o_is_inf, o_is_zero} & {3{o_valid & i_ready}};

    // Clear takes effect before a same-cycle event is counted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flag_q <= '0;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (i_flag_clr) begin
                    flag_q[k] <= event_vec[k];
                    cnt_q[k]  <= CNT_W'(event_vec[k]);
                end else if (event_vec[k]) begin
                    flag_q[k] <= 1'b1;
                    if (cnt_q[k] != {CNT_W{1'b1}}) begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_flag_nan  = flag_q[2];
    assign o_flag_inf  = flag_q[1];
    assign o_flag_zero = flag_q[0];
    assign o_cnt_nan   = cnt_q[2];
    assign o_cnt_inf   = cnt_q[1];
    assign o_cnt_zero  = cnt_q[0];
`else
    logic unused_flag_clr;

    assign unused_flag_clr = i_flag_clr;
    assign o_flag_nan      = 1'b0;
    assign o_flag_inf      = 1'b0;
    assign o_flag_zero     = 1'b0;
    assign o_cnt_nan       = '0;
    assign o_cnt_inf       = '0;
    assign o_cnt_zero      = '0;
`endif

endmodule
